// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
//
// Sequential execution unit for the EX stage of the multi-cycle CPU. It takes
// the 4-bit ALU control code and two operands and returns a registered result
// through a start/busy/done handshake.
//
// AND, OR, ADD, SUB, SLT and illegal codes complete at the accept edge. MUL
// (4'b1000) runs a shift-add multiply for WIDTH cycles.
//
// Optional feature macro: ALU_SEQ_OVF_EN
//   defined   -> overflow_o registers signed overflow of the last ADD/SUB
//   undefined -> overflow_o is tied to 0
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-low reset
//   start_i     request, sampled only while busy_o=0
//   ctrl_i      op code (AND/OR/ADD/SUB/SLT/MUL, anything else is illegal)
//   src1_i      operand A
//   src2_i      operand B
//   busy_o      multiply in progress
//   done_o      one-cycle pulse; result_o/zero_o/err_o are valid
//   result_o    registered result, held until the next completion
//   zero_o      result_o == 0
//   err_o       last completed op had an illegal code
//   overflow_o  signed overflow of the last ADD/SUB
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             err_o,
  output logic             overflow_o
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_MUL = 4'b1000;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             accept_mul;
  logic             accept_single;
  logic             mul_last;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] op_result;
  logic             op_err;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;
  logic             done_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_next    = state;
    accept        = 1'b0;
    accept_mul    = 1'b0;
    accept_single = 1'b0;
    mul_last      = 1'b0;
    busy_o        = 1'b0;
    case (state)
      IDLE: begin
        accept        = start_i;
        accept_mul    = start_i && (ctrl_i == CTRL_MUL);
        accept_single = start_i && (ctrl_i != CTRL_MUL);
        if (accept_mul) begin
          state_next = MUL;
        end
      end
      MUL: begin
        busy_o   = 1'b1;
        mul_last = (cnt == LAST_CNT);
        if (mul_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sum  = src1_i + src2_i;
  assign diff = src1_i - src2_i;

  // Result of the single-cycle ops straight from the live operands
  always_comb begin
    op_result = '0;
    op_err    = 1'b0;
    case (ctrl_i)
      CTRL_AND: op_result = src1_i & src2_i;
      CTRL_OR:  op_result = src1_i | src2_i;
      CTRL_ADD: op_result = sum;
      CTRL_SUB: op_result = diff;
      CTRL_SLT: op_result = {{(WIDTH-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
      CTRL_MUL: op_result = '0;
      default:  op_err    = 1'b1;
    endcase
  end

  // One shift-add step; the final step's sum is the product written out
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  // Multiplier datapath; the internal copies make operand changes harmless
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept_mul) begin
      mcand  <= src1_i;
      mplier <= src2_i;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Completion registers; done pulses for the cycle after any completion
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept_single) begin
        result_q <= op_result;
        zero_q   <= (op_result == '0);
        err_q    <= op_err;
        done_q   <= 1'b1;
      end else if (mul_last) begin
        result_q <= acc_next;
        zero_q   <= (acc_next == '0);
        err_q    <= 1'b0;
        done_q   <= 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic op_ovf;
  logic ovf_q;

  // ADD overflows when equal-signed operands give a result of the other sign;
  // SUB overflows when the operand signs differ and the sign of A is lost
  always_comb begin
    op_ovf = 1'b0;
    case (ctrl_i)
      CTRL_ADD: op_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) &&
                         (sum[WIDTH-1] != src1_i[WIDTH-1]);
      CTRL_SUB: op_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) &&
                         (diff[WIDTH-1] != src1_i[WIDTH-1]);
      default:  op_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ovf_q <= 1'b0;
    end else if (accept_single) begin
      ovf_q <= op_ovf;
    end else if (mul_last) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
//
// Directed self-checking bench for alu_seq (WIDTH=32). Each scenario task
// drives its own vectors and compares against hand-computed values. Outputs
// are sampled 1 ns after the rising edge; inputs change at the same point.
// Expected overflow for the ADD 0x7FFFFFFF+1 case follows ALU_SEQ_OVF_EN.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_BAD = 4'b1111;

`ifdef ALU_SEQ_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;
  logic             overflow;

  int pass_cnt  = 0;
  int check_cnt = 0;

  alu_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .start_i    (start),
    .ctrl_i     (ctrl),
    .src1_i     (src1),
    .src2_i     (src2),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .zero_o     (zero),
    .err_o      (err),
    .overflow_o (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] c,
                       input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    start = s;
    ctrl  = c;
    src1  = a;
    src2  = b;
  endtask

  task automatic test_reset();
    drive(1'b0, OP_AND, '0, '0);
    rst_n = 1'b0;
    #12;
    check_cnt++;
    if ({busy, done, err, overflow, zero} !== 5'b00001) begin
      $display("[TB] FAIL reset_flags: got busy/done/err/ovf/zero=%b expected 00001",
               {busy, done, err, overflow, zero});
    end else pass_cnt++;
    check_cnt++;
    if (result !== 32'd0) begin
      $display("[TB] FAIL reset_result: got %0d expected 0", result);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    drive(1'b1, OP_ADD, 32'd5, 32'd7);
    step();
    drive(1'b0, OP_ADD, '0, '0);
    check_cnt++;
    if ({done, busy, zero} !== 3'b100 || result !== 32'd12) begin
      $display("[TB] FAIL add_5_7: got done/busy/zero=%b result=%0d expected 100 result=12",
               {done, busy, zero}, result);
    end else pass_cnt++;
    step();
    check_cnt++;
    if (done !== 1'b0 || result !== 32'd12) begin
      $display("[TB] FAIL add_hold: got done=%b result=%0d expected done=0 result=12",
               done, result);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    drive(1'b1, OP_SUB, 32'd9, 32'd9);
    step();
    check_cnt++;
    if (done !== 1'b1 || result !== 32'd0 || zero !== 1'b1) begin
      $display("[TB] FAIL b2b_sub: got done=%b result=%0d zero=%b expected 1 0 1",
               done, result, zero);
    end else pass_cnt++;
    drive(1'b1, OP_SLT, 32'hFFFF_FFFD, 32'd2);
    step();
    check_cnt++;
    if (done !== 1'b1 || result !== 32'd1 || zero !== 1'b0) begin
      $display("[TB] FAIL b2b_slt: got done=%b result=%0d zero=%b expected 1 1 0",
               done, result, zero);
    end else pass_cnt++;
    drive(1'b1, OP_OR, 32'h0000_00F0, 32'h0000_000F);
    step();
    drive(1'b0, OP_AND, '0, '0);
    check_cnt++;
    if (done !== 1'b1 || result !== 32'h0000_00FF) begin
      $display("[TB] FAIL b2b_or: got done=%b result=%h expected 1 000000ff",
               done, result);
    end else pass_cnt++;
    // AND and unsigned-looking SLT boundary: 2 < -3 is false when signed
    drive(1'b1, OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00);
    step();
    check_cnt++;
    if (result !== 32'h00F0_1200) begin
      $display("[TB] FAIL b2b_and: got %h expected 00f01200", result);
    end else pass_cnt++;
    drive(1'b1, OP_SLT, 32'd2, 32'hFFFF_FFFD);
    step();
    drive(1'b0, OP_AND, '0, '0);
    check_cnt++;
    if (result !== 32'd0 || zero !== 1'b1) begin
      $display("[TB] FAIL slt_signed: got result=%0d zero=%b expected 0 1", result, zero);
    end else pass_cnt++;
    step();
  endtask

  task automatic test_mul();
    int edges;
    int busy_seen;
    bit early_done;
    drive(1'b1, OP_MUL, 32'd123, 32'd456);
    step();
    drive(1'b0, OP_AND, 32'hDEAD_BEEF, 32'h1234_5678);
    edges      = 0;
    busy_seen  = busy ? 1 : 0;
    early_done = done;
    while (edges < 40 && done !== 1'b1) begin
      // A second request mid-multiply must be dropped, not queued
      if (edges == 5) drive(1'b1, OP_ADD, 32'd1, 32'd1);
      else            drive(1'b0, OP_AND, 32'hDEAD_BEEF, 32'h1234_5678);
      step();
      edges++;
      if (busy === 1'b1) busy_seen++;
    end
    drive(1'b0, OP_AND, '0, '0);
    check_cnt++;
    if (early_done !== 1'b0) begin
      $display("[TB] FAIL mul_early_done: done=1 right after accept, expected 0");
    end else pass_cnt++;
    // Accept edge plus WIDTH multiply edges: done appears WIDTH edges later
    check_cnt++;
    if (edges !== WIDTH || done !== 1'b1) begin
      $display("[TB] FAIL mul_latency: done after %0d edges (done=%b) expected %0d",
               edges, done, WIDTH);
    end else pass_cnt++;
    check_cnt++;
    if (busy_seen !== WIDTH) begin
      $display("[TB] FAIL mul_busy_cycles: got %0d expected %0d", busy_seen, WIDTH);
    end else pass_cnt++;
    check_cnt++;
    if (result !== 32'd56088 || zero !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      $display("[TB] FAIL mul_result: got %0d zero=%b err=%b busy=%b expected 56088 0 0 0",
               result, zero, err, busy);
    end else pass_cnt++;
    step();
    check_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd56088) begin
      $display("[TB] FAIL mul_no_queue: got done=%b busy=%b result=%0d expected 0 0 56088",
               done, busy, result);
    end else pass_cnt++;
  endtask

  task automatic test_illegal();
    drive(1'b1, OP_BAD, 32'd1, 32'd1);
    step();
    check_cnt++;
    if (done !== 1'b1 || result !== 32'd0 || err !== 1'b1 || zero !== 1'b1) begin
      $display("[TB] FAIL illegal_op: got done=%b result=%0d err=%b zero=%b expected 1 0 1 1",
               done, result, err, zero);
    end else pass_cnt++;
    drive(1'b1, OP_ADD, 32'd1, 32'd1);
    step();
    drive(1'b0, OP_AND, '0, '0);
    check_cnt++;
    if (done !== 1'b1 || result !== 32'd2 || err !== 1'b0) begin
      $display("[TB] FAIL illegal_clear: got done=%b result=%0d err=%b expected 1 2 0",
               done, result, err);
    end else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_mul();
    int done_hits;
    drive(1'b1, OP_MUL, 32'd1000, 32'd1000);
    step();
    drive(1'b0, OP_AND, '0, '0);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (busy !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || done !== 1'b0) begin
      $display("[TB] FAIL reset_abort: got busy=%b result=%0d zero=%b done=%b expected 0 0 1 0",
               busy, result, zero, done);
    end else pass_cnt++;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    done_hits = 0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      step();
      if (done === 1'b1) done_hits++;
    end
    check_cnt++;
    if (done_hits !== 0 || busy !== 1'b0) begin
      $display("[TB] FAIL reset_no_done: got %0d done pulses busy=%b expected 0 0",
               done_hits, busy);
    end else pass_cnt++;
    drive(1'b1, OP_ADD, 32'd3, 32'd4);
    step();
    drive(1'b0, OP_AND, '0, '0);
    check_cnt++;
    if (done !== 1'b1 || result !== 32'd7) begin
      $display("[TB] FAIL reset_then_add: got done=%b result=%0d expected 1 7", done, result);
    end else pass_cnt++;
    step();
  endtask

  task automatic test_overflow();
    drive(1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    step();
    check_cnt++;
    if (result !== 32'h8000_0000 || overflow !== OVF_EXP) begin
      $display("[TB] FAIL add_ovf: got result=%h ovf=%b expected 80000000 %b",
               result, overflow, OVF_EXP);
    end else pass_cnt++;
    drive(1'b1, OP_SUB, 32'h8000_0000, 32'd1);
    step();
    check_cnt++;
    if (result !== 32'h7FFF_FFFF || overflow !== OVF_EXP) begin
      $display("[TB] FAIL sub_ovf: got result=%h ovf=%b expected 7fffffff %b",
               result, overflow, OVF_EXP);
    end else pass_cnt++;
    drive(1'b1, OP_ADD, 32'd5, 32'hFFFF_FFFF);
    step();
    drive(1'b0, OP_AND, '0, '0);
    check_cnt++;
    if (result !== 32'd4 || overflow !== 1'b0) begin
      $display("[TB] FAIL add_no_ovf: got result=%0d ovf=%b expected 4 0", result, overflow);
    end else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_illegal();
    test_reset_mid_mul();
    test_overflow();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
